// File: rtl/arilla_bus_arbiter.sv
// arilla_bus_arbiter
// N-controller front end for the shared arilla bus. Picks one requesting
// controller per cycle (rotating or fixed priority), forwards its access to
// the bus, holds the bus for that controller while the peripheral inhibits,
// aborts after a bounded number of inhibited cycles and reports unclaimed
// or aborted accesses as a one-cycle fault pulse.
module arilla_bus_arbiter #(
    parameter int NumControllers   = 2,
    parameter int DataWidth        = 32,
    parameter int ByteAddressWidth = 32,
    parameter int ByteSize         = 8,
    parameter int RoundRobin       = 1,
    parameter int InhibitTimeout   = 16,
    localparam int BPW = DataWidth / ByteSize,
    localparam int WAW = ByteAddressWidth - $clog2(BPW),
    localparam int N   = NumControllers
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       c_read,
    input  logic [N-1:0]       c_write,
    input  logic [N*WAW-1:0]   c_address,
    input  logic [N*DataWidth-1:0] c_data_ctp,
    input  logic [N*BPW-1:0]   c_byte_enable,
    output logic [DataWidth-1:0] c_data_ptc,
    output logic [N-1:0]       c_grant,
    output logic [N-1:0]       c_fault,
    output logic               b_read,
    output logic               b_write,
    output logic [WAW-1:0]     b_address,
    output logic [DataWidth-1:0] b_data_ctp,
    output logic [BPW-1:0]     b_byte_enable,
    input  logic [DataWidth-1:0] b_data_ptc,
    input  logic               b_hit,
    input  logic               b_inhibit,
    input  logic               b_intercept
);

    localparam int PtrW = (N > 1) ? $clog2(N) : 1;
    localparam int TcW  = (InhibitTimeout > 0) ? $clog2(InhibitTimeout + 1) : 1;
    localparam logic [TcW-1:0]  TcLast = TcW'((InhibitTimeout > 0) ? InhibitTimeout - 1 : 0);
    localparam logic [TcW-1:0]  TcMax  = {TcW{1'b1}};
    localparam logic [PtrW:0]   NCount = (PtrW + 1)'(N);

    logic [N-1:0]    req;
    logic [PtrW-1:0] ptr;
    logic [PtrW-1:0] owner;
    logic            locked;
    logic [TcW-1:0]  tcount;

    logic [PtrW-1:0] sel;
    logic            active;
    logic            owner_req;
    logic [PtrW:0]   scan_idx;
    logic [PtrW:0]   ptr_inc;
    logic [PtrW-1:0] next_ptr;
    logic [TcW-1:0]  tcount_eff;
    logic            timeout;
    logic            done;
    logic            fault_now;
    logic [N-1:0]    fault_vec;

    assign req        = c_read | c_write;
    assign owner_req  = req[owner];
    assign c_data_ptc = b_data_ptc;

    // Choose this cycle's bus owner: a locked owner keeps the bus while it
    // still requests, otherwise scan from ptr (rotating) or from index 0.
    always_comb begin
        sel      = '0;
        active   = 1'b0;
        scan_idx = '0;
        if (locked && owner_req) begin
            sel    = owner;
            active = 1'b1;
        end else if (RoundRobin != 0) begin
            for (int k = 0; k < N; k++) begin
                scan_idx = {1'b0, ptr} + (PtrW + 1)'(k);
                if (scan_idx >= NCount) begin
                    scan_idx = scan_idx - NCount;
                end
                if (!active && req[scan_idx[PtrW-1:0]]) begin
                    sel    = scan_idx[PtrW-1:0];
                    active = 1'b1;
                end
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                if (req[k]) begin
                    sel    = PtrW'(k);
                    active = 1'b1;
                end
            end
        end
    end

    // Completion, timeout and fault decisions; a dropped lock restarts the
    // inhibit count so a new owner never inherits the old owner's cycles.
    always_comb begin
        tcount_eff = (locked && !owner_req) ? '0 : tcount;
        timeout    = (InhibitTimeout != 0) && (tcount_eff == TcLast) && b_inhibit;
        done       = active && (!b_inhibit || timeout);
        fault_now  = done && (!(b_hit || b_intercept) || timeout);
        ptr_inc    = {1'b0, sel} + (PtrW + 1)'(1);
        next_ptr   = (ptr_inc >= NCount) ? '0 : ptr_inc[PtrW-1:0];
        fault_vec  = '0;
        if (fault_now) begin
            fault_vec[sel] = 1'b1;
        end
    end

    // Drive the shared bus from the selected controller and strobe its grant.
    always_comb begin
        b_read        = 1'b0;
        b_write       = 1'b0;
        b_address     = '0;
        b_data_ctp    = '0;
        b_byte_enable = '0;
        c_grant       = '0;
        if (active) begin
            b_read        = c_read[sel];
            b_write       = c_write[sel];
            b_address     = c_address[sel*WAW +: WAW];
            b_data_ctp    = c_data_ctp[sel*DataWidth +: DataWidth];
            b_byte_enable = c_byte_enable[sel*BPW +: BPW];
        end
        if (done) begin
            c_grant[sel] = 1'b1;
        end
    end

    // Rotation pointer, grant lock and saturating inhibit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr    <= '0;
            owner  <= '0;
            locked <= 1'b0;
            tcount <= '0;
        end else if (done) begin
            ptr    <= next_ptr;
            locked <= 1'b0;
            tcount <= '0;
        end else if (active && b_inhibit) begin
            locked <= 1'b1;
            owner  <= sel;
            tcount <= (tcount_eff == TcMax) ? tcount_eff : tcount_eff + TcW'(1);
        end else begin
            locked <= 1'b0;
            tcount <= '0;
        end
    end

    // One-cycle fault pulse for the controller whose access just ended badly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_fault <= '0;
        end else begin
            c_fault <= fault_vec;
        end
    end

endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// tb_arilla_bus_arbiter
// Drives a rotating-priority and a fixed-priority arbiter (three controllers,
// inhibit timeout of four) from one vector table; expected values are queued
// when each vector is applied and compared when the outputs are sampled.
module tb_arilla_bus_arbiter;

    localparam int N   = 3;
    localparam int DW  = 32;
    localparam int BPW = 4;
    localparam int WAW = 30;

    typedef struct {
        logic [2:0]  rd;
        logic [2:0]  wr;
        logic        inh;
        logic        hit;
        logic        icp;
        int          sel;
        logic [2:0]  grant;
        logic [2:0]  fault;
        int          fsel;
        logic [2:0]  fgrant;
        logic [31:0] ptc;
        int          id;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      c_read;
    logic [N-1:0]      c_write;
    logic [N*WAW-1:0]  c_address;
    logic [N*DW-1:0]   c_data_ctp;
    logic [N*BPW-1:0]  c_byte_enable;
    logic [DW-1:0]     b_data_ptc;
    logic              b_hit;
    logic              b_inhibit;
    logic              b_intercept;

    logic [DW-1:0]     rr_c_data_ptc;
    logic [N-1:0]      rr_c_grant;
    logic [N-1:0]      rr_c_fault;
    logic              rr_b_read;
    logic              rr_b_write;
    logic [WAW-1:0]    rr_b_address;
    logic [DW-1:0]     rr_b_data_ctp;
    logic [BPW-1:0]    rr_b_byte_enable;

    logic [DW-1:0]     fx_c_data_ptc;
    logic [N-1:0]      fx_c_grant;
    logic [N-1:0]      fx_c_fault;
    logic              fx_b_read;
    logic              fx_b_write;
    logic [WAW-1:0]    fx_b_address;
    logic [DW-1:0]     fx_b_data_ctp;
    logic [BPW-1:0]    fx_b_byte_enable;

    logic [WAW-1:0]    addr_tbl [N];
    logic [DW-1:0]     data_tbl [N];
    logic [BPW-1:0]    be_tbl   [N];

    vec_t vecs [$];
    vec_t exp_q [$];
    int   errors = 0;
    int   checks = 0;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    arilla_bus_arbiter #(
        .NumControllers(N), .DataWidth(DW), .ByteAddressWidth(32), .ByteSize(8),
        .RoundRobin(1), .InhibitTimeout(4)
    ) u_rr (
        .clk(clk), .rst(rst),
        .c_read(c_read), .c_write(c_write), .c_address(c_address),
        .c_data_ctp(c_data_ctp), .c_byte_enable(c_byte_enable),
        .c_data_ptc(rr_c_data_ptc), .c_grant(rr_c_grant), .c_fault(rr_c_fault),
        .b_read(rr_b_read), .b_write(rr_b_write), .b_address(rr_b_address),
        .b_data_ctp(rr_b_data_ctp), .b_byte_enable(rr_b_byte_enable),
        .b_data_ptc(b_data_ptc), .b_hit(b_hit), .b_inhibit(b_inhibit),
        .b_intercept(b_intercept)
    );

    arilla_bus_arbiter #(
        .NumControllers(N), .DataWidth(DW), .ByteAddressWidth(32), .ByteSize(8),
        .RoundRobin(0), .InhibitTimeout(4)
    ) u_fx (
        .clk(clk), .rst(rst),
        .c_read(c_read), .c_write(c_write), .c_address(c_address),
        .c_data_ctp(c_data_ctp), .c_byte_enable(c_byte_enable),
        .c_data_ptc(fx_c_data_ptc), .c_grant(fx_c_grant), .c_fault(fx_c_fault),
        .b_read(fx_b_read), .b_write(fx_b_write), .b_address(fx_b_address),
        .b_data_ctp(fx_b_data_ctp), .b_byte_enable(fx_b_byte_enable),
        .b_data_ptc(b_data_ptc), .b_hit(b_hit), .b_inhibit(b_inhibit),
        .b_intercept(b_intercept)
    );

    function automatic vec_t mk(input logic [2:0] rd, input logic [2:0] wr,
                                input logic inh, input logic hit, input logic icp,
                                input int sel, input logic [2:0] grant,
                                input logic [2:0] fault, input int fsel,
                                input logic [2:0] fgrant);
        vec_t v;
        v.rd = rd; v.wr = wr; v.inh = inh; v.hit = hit; v.icp = icp;
        v.sel = sel; v.grant = grant; v.fault = fault;
        v.fsel = fsel; v.fgrant = fgrant;
        v.ptc = '0; v.id = 0;
        return v;
    endfunction

    task automatic cmp(input string name, input int id,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (vector %0d): got 0x%0h, required 0x%0h", name, id, act, exp);
        end
    endtask

    task automatic check_bus(input string pfx, input int id, input int sel,
                             input logic [2:0] rd, input logic [2:0] wr,
                             input logic a_read, input logic a_write,
                             input logic [WAW-1:0] a_addr, input logic [DW-1:0] a_data,
                             input logic [BPW-1:0] a_be);
        logic           e_read;
        logic           e_write;
        logic [WAW-1:0] e_addr;
        logic [DW-1:0]  e_data;
        logic [BPW-1:0] e_be;
        e_read = 1'b0; e_write = 1'b0; e_addr = '0; e_data = '0; e_be = '0;
        if (sel >= 0) begin
            e_read  = rd[sel];
            e_write = wr[sel];
            e_addr  = addr_tbl[sel];
            e_data  = data_tbl[sel];
            e_be    = be_tbl[sel];
        end
        cmp({pfx, " b_read"},        id, 64'(a_read),  64'(e_read));
        cmp({pfx, " b_write"},       id, 64'(a_write), 64'(e_write));
        cmp({pfx, " b_address"},     id, 64'(a_addr),  64'(e_addr));
        cmp({pfx, " b_data_ctp"},    id, 64'(a_data),  64'(e_data));
        cmp({pfx, " b_byte_enable"}, id, 64'(a_be),    64'(e_be));
    endtask

    task automatic apply_stimulus(input vec_t v, input int id);
        vec_t e;
        c_read      = v.rd;
        c_write     = v.wr;
        b_inhibit   = v.inh;
        b_hit       = v.hit;
        b_intercept = v.icp;
        b_data_ptc  = 32'h5000_0000 + 32'(id);
        e     = v;
        e.ptc = b_data_ptc;
        e.id  = id;
        exp_q.push_back(e);
    endtask

    task automatic check_output();
        vec_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue, required one pending entry");
            return;
        end
        e = exp_q.pop_front();
        cmp("rr c_grant",    e.id, 64'(rr_c_grant),    64'(e.grant));
        cmp("rr c_fault",    e.id, 64'(rr_c_fault),    64'(e.fault));
        cmp("rr c_data_ptc", e.id, 64'(rr_c_data_ptc), 64'(e.ptc));
        check_bus("rr", e.id, e.sel, e.rd, e.wr, rr_b_read, rr_b_write,
                  rr_b_address, rr_b_data_ctp, rr_b_byte_enable);
        cmp("fx c_grant",    e.id, 64'(fx_c_grant),    64'(e.fgrant));
        cmp("fx c_fault",    e.id, 64'(fx_c_fault),    64'(e.fault));
        cmp("fx c_data_ptc", e.id, 64'(fx_c_data_ptc), 64'(e.ptc));
        check_bus("fx", e.id, e.fsel, e.rd, e.wr, fx_b_read, fx_b_write,
                  fx_b_address, fx_b_data_ctp, fx_b_byte_enable);
    endtask

    // Safety net so a stuck run still ends with a visible failure.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, required finish before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    // Vector table, reset, table sweep, then the reset-during-lock sequence.
    initial begin
        addr_tbl[0] = 30'h100; addr_tbl[1] = 30'h200; addr_tbl[2] = 30'h300;
        data_tbl[0] = 32'hA000_0000; data_tbl[1] = 32'hA000_0001; data_tbl[2] = 32'hA000_0002;
        be_tbl[0]   = 4'hF; be_tbl[1] = 4'h3; be_tbl[2] = 4'hC;
        for (int i = 0; i < N; i++) begin
            c_address[i*WAW +: WAW]   = addr_tbl[i];
            c_data_ctp[i*DW +: DW]    = data_tbl[i];
            c_byte_enable[i*BPW +: BPW] = be_tbl[i];
        end

        // rd, wr, inh, hit, icp, sel, grant, fault, fsel, fgrant
        vecs.push_back(mk(3'b000, 3'b000, 0, 1, 0, -1, 3'b000, 3'b000, -1, 3'b000)); // 0 idle after reset
        vecs.push_back(mk(3'b111, 3'b000, 0, 1, 0,  0, 3'b001, 3'b000,  0, 3'b001)); // 1 rotation
        vecs.push_back(mk(3'b111, 3'b000, 0, 1, 0,  1, 3'b010, 3'b000,  0, 3'b001));
        vecs.push_back(mk(3'b111, 3'b000, 0, 1, 0,  2, 3'b100, 3'b000,  0, 3'b001));
        vecs.push_back(mk(3'b111, 3'b000, 0, 1, 0,  0, 3'b001, 3'b000,  0, 3'b001));
        vecs.push_back(mk(3'b011, 3'b000, 1, 1, 0,  1, 3'b000, 3'b000,  0, 3'b000)); // 5 inhibit lock
        vecs.push_back(mk(3'b011, 3'b000, 1, 1, 0,  1, 3'b000, 3'b000,  0, 3'b000));
        vecs.push_back(mk(3'b011, 3'b000, 1, 1, 0,  1, 3'b000, 3'b000,  0, 3'b000));
        vecs.push_back(mk(3'b011, 3'b000, 0, 1, 0,  1, 3'b010, 3'b000,  0, 3'b001));
        vecs.push_back(mk(3'b011, 3'b000, 0, 1, 0,  0, 3'b001, 3'b000,  0, 3'b001)); // 9 ptr wraps
        vecs.push_back(mk(3'b001, 3'b000, 1, 1, 0,  0, 3'b000, 3'b000,  0, 3'b000)); // 10 timeout
        vecs.push_back(mk(3'b001, 3'b000, 1, 1, 0,  0, 3'b000, 3'b000,  0, 3'b000));
        vecs.push_back(mk(3'b001, 3'b000, 1, 1, 0,  0, 3'b000, 3'b000,  0, 3'b000));
        vecs.push_back(mk(3'b001, 3'b000, 1, 1, 0,  0, 3'b001, 3'b000,  0, 3'b001));
        vecs.push_back(mk(3'b000, 3'b000, 0, 1, 0, -1, 3'b000, 3'b001, -1, 3'b000)); // 14 fault pulse
        vecs.push_back(mk(3'b001, 3'b000, 1, 1, 0,  0, 3'b000, 3'b000,  0, 3'b000)); // 15 count restarted
        vecs.push_back(mk(3'b001, 3'b000, 0, 1, 0,  0, 3'b001, 3'b000,  0, 3'b001));
        vecs.push_back(mk(3'b000, 3'b000, 0, 1, 0, -1, 3'b000, 3'b000, -1, 3'b000));
        vecs.push_back(mk(3'b000, 3'b001, 0, 0, 0,  0, 3'b001, 3'b000,  0, 3'b001)); // 18 unmapped write
        vecs.push_back(mk(3'b000, 3'b000, 0, 0, 0, -1, 3'b000, 3'b001, -1, 3'b000));
        vecs.push_back(mk(3'b000, 3'b001, 0, 0, 1,  0, 3'b001, 3'b000,  0, 3'b001)); // 20 intercepted
        vecs.push_back(mk(3'b000, 3'b000, 0, 0, 0, -1, 3'b000, 3'b000, -1, 3'b000));
        vecs.push_back(mk(3'b010, 3'b010, 0, 1, 0,  1, 3'b010, 3'b000,  1, 3'b010)); // 22 read+write
        vecs.push_back(mk(3'b101, 3'b000, 0, 1, 0,  2, 3'b100, 3'b000,  0, 3'b001)); // 23 fixed priority
        vecs.push_back(mk(3'b101, 3'b000, 0, 1, 0,  0, 3'b001, 3'b000,  0, 3'b001));
        vecs.push_back(mk(3'b101, 3'b000, 0, 1, 0,  2, 3'b100, 3'b000,  0, 3'b001));

        rst = 1'b1;
        c_read = '0; c_write = '0;
        b_hit = 1'b0; b_inhibit = 1'b0; b_intercept = 1'b0; b_data_ptc = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        $display("[TB] reset released, applying %0d vectors", vecs.size());

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1 apply_stimulus(vecs[i], i);
            @(negedge clk);
            check_output();
        end

        // Lock both arbiters onto controller 1, then reset in the middle of it.
        @(posedge clk);
        #1 apply_stimulus(mk(3'b010, 3'b000, 1, 1, 0, 1, 3'b000, 3'b000, 1, 3'b000), 100);
        @(negedge clk);
        check_output();

        @(posedge clk);
        #1 rst = 1'b1;
        apply_stimulus(mk(3'b000, 3'b000, 1, 1, 0, -1, 3'b000, 3'b000, -1, 3'b000), 101);
        #1 check_output();
        #2 rst = 1'b0;

        // With the lock gone and ptr back at 0, controller 0 wins over 1.
        @(posedge clk);
        #1 apply_stimulus(mk(3'b011, 3'b000, 0, 1, 0, 0, 3'b001, 3'b000, 0, 3'b001), 102);
        @(negedge clk);
        check_output();

        @(posedge clk);
        #1 apply_stimulus(mk(3'b000, 3'b000, 0, 1, 0, -1, 3'b000, 3'b000, -1, 3'b000), 103);
        @(negedge clk);
        check_output();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arilla_bus_arbiter.md
Name: arilla_bus_arbiter

Overview:
- Parametrised N-controller front end for the arilla bus. Multiplexes independent controller ports (core fetch, core data, debug module) onto one shared arilla bus.
- Arbitration is round-robin or fixed-priority.
- Adds behaviour the plain bus lacks: inhibit-driven wait states with grant locking, per-controller completion strobes, registered fault reporting, and an inhibit timeout.
- Sits between controllers and the peripheral-side arilla bus in the system block.

Parameters:
- NumControllers, 2, number of controller ports, 1..8.
- DataWidth, 32, bus data width in bits.
- ByteAddressWidth, 32, byte address width.
- ByteSize, 8, bits per byte lane.
- RoundRobin, 1, 1 = rotating priority, 0 = fixed priority with lowest index highest.
- InhibitTimeout, 16, maximum consecutive inhibited cycles before abort; 0 disables the timeout.

Derived values:
- BPW = DataWidth/ByteSize.
- WAW = ByteAddressWidth - clog2(BPW).
- N = NumControllers.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- c_read  in  N  per-controller read request.
- c_write  in  N  per-controller write request.
- c_address  in  N*WAW  word address; controller i occupies slice i.
- c_data_ctp  in  N*DW  write data.
- c_byte_enable  in  N*BPW  byte lanes.
- c_data_ptc  out  DW  read data, broadcast to all controllers.
- c_grant  out  N  one-hot completion strobe.
- c_fault  out  N  registered fault pulse.
- b_read  out  1  bus read.
- b_write  out  1  bus write.
- b_address  out  WAW  bus address.
- b_data_ctp  out  DW  bus write data.
- b_byte_enable  out  BPW  bus byte lanes.
- b_data_ptc  in  DW  bus read data.
- b_hit  in  1  a peripheral decoded the address.
- b_inhibit  in  1  peripheral stalls the current access.
- b_intercept  in  1  debug logic claims the access.

Behaviour:
- Clocking and reset: single clock domain. rst asserted at any time immediately sets ptr=0, locked=0, owner=0, tcount=0, c_fault=0. No transaction survives reset.
- Request: req[i] = c_read[i] | c_write[i]. The controller must hold all its signals stable until c_grant[i].
- Owner selection (combinational):
  - If locked=1 and req[owner]=1, sel=owner.
  - Else, with RoundRobin=1, sel is the first requester scanning from ptr upward, wrapping modulo N.
  - Else (RoundRobin=0), sel is the lowest-index requester.
  - No requester: idle.
- Bus drive:
  - Idle: b_read=b_write=0; b_address, b_data_ctp and b_byte_enable all zero.
  - Otherwise, forward controller sel's fields unmodified.
  - c_data_ptc = b_data_ptc always.
- Completion:
  - done = active & !b_inhibit, or active & timeout.
  - c_grant[sel] = done, combinational, same cycle. Zero latency for uninhibited accesses.
- Wait state:
  - active & b_inhibit & !timeout: locked<=1, owner<=sel, tcount<=tcount+1.
  - Other controllers cannot win while locked.
- Timeout:
  - timeout = (InhibitTimeout!=0) & (tcount==InhibitTimeout-1) & b_inhibit.
  - The access is aborted: c_grant pulses and a fault is flagged.
- On done:
  - ptr <= (sel+1) mod N. ptr is unused in fixed mode.
  - locked<=0, tcount<=0.
- Lock release without completion: if the owner drops its request while locked, set locked<=0 and tcount<=0. ptr is unchanged and no grant is issued.
- Fault:
  - c_fault[sel] <= 1 for exactly one cycle after a done cycle where (b_hit|b_intercept)==0 or timeout=1.
  - b_intercept counts as a claim.
  - c_fault is otherwise 0.
- Simultaneous read and write from one controller: both are forwarded as-is. Decoding is the peripheral's responsibility.
- N=1: the arbiter degenerates to a pass-through with wait-state handling, timeout and fault logic. ptr stays 0.
- tcount width: clog2(InhibitTimeout+1), minimum 1. It saturates and never wraps.

Test Plan:
- Reset/idle: rst=1, then release with no requests -> all b_* outputs 0, c_grant=0, c_fault=0.
- Round-robin: N=3, all three request reads every cycle, no inhibit, b_hit=1 -> c_grant sequence 001, 010, 100, 001. b_address tracks the owner each cycle.
- Fixed priority: RoundRobin=0, controllers 0 and 2 requesting continuously -> controller 0 is granted every cycle and controller 2 never.
- Inhibit lock: controller 1 is owner; b_inhibit=1 for 3 cycles while controller 0 also requests -> bus stays on controller 1 with no grants. c_grant=010 in cycle 4, then controller 0 next cycle (ptr=2 wraps to 0).
- Timeout: InhibitTimeout=4, b_inhibit held high -> c_grant[0] on the 4th inhibited cycle. c_fault[0]=1 on the following cycle only. tcount returns to 0.
- Unmapped/intercept: write to address 0x100 with b_hit=0, b_intercept=0 -> grant, then a one-cycle fault. Repeat with b_intercept=1 -> no fault. Assert rst mid-lock -> locked clears immediately and the bus goes idle.
